// File: rtl/gen_io_pkg.sv
// Shared types and constants for the port-B I/O blocks (Team Player multitap).
package gen_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TYPE,
        DATA,
        END
    } tp_state_t;

    localparam logic [3:0] TP_TYPE_3BTN = 4'h0;
    localparam logic [3:0] TP_TYPE_6BTN = 4'h1;
    localparam logic [3:0] TP_TYPE_NONE = 4'hF;

    localparam logic [3:0] TP_HDR0 = 4'h3;
    localparam logic [3:0] TP_HDR1 = 4'hF;

    // Data nibbles a port contributes to the packet: 0, 2 or 3.
    function automatic logic [4:0] tp_port_len(input logic present, input logic six);
        if (!present)
            tp_port_len = 5'd0;
        else if (six)
            tp_port_len = 5'd3;
        else
            tp_port_len = 5'd2;
    endfunction

endpackage

// File: rtl/tp_nibble_sel.sv
// Combinational nibble lookup for the Team Player packet: maps a nibble index
// to the header/type/data nibble and flags the final nibble of the packet.
module tp_nibble_sel
    import gen_io_pkg::*;
(
    input  logic [3:0]  present,
    input  logic [3:0]  six,
    input  logic [4:0]  idx,
    input  logic [47:0] pad_btn,
    output logic [3:0]  nibble,
    output logic        last
);

    logic [4:0]  len [4];
    logic [4:0]  total;
    logic [4:0]  k;
    logic [4:0]  base;
    logic [4:0]  sub;
    logic [1:0]  port;
    logic        found;
    logic [11:0] btn;

    always_comb begin
        total = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            len[p] = tp_port_len(present[p], six[p]);
            total  = total + len[p];
        end
    end

    // Walk the ports in order A..D, skipping absent ones, to find which port
    // and which of its nibbles data slot k belongs to.
    always_comb begin
        k     = idx - 5'd8;
        base  = '0;
        sub   = '0;
        port  = '0;
        found = 1'b0;
        for (int unsigned p = 0; p < 4; p++) begin
            if (!found && (k < base + len[p])) begin
                found = 1'b1;
                port  = 2'(p);
                sub   = k - base;
            end
            base = base + len[p];
        end
    end

    assign btn = pad_btn[12*port +: 12];

    always_comb begin
        nibble = TP_TYPE_NONE;
        if (idx == 5'd0) begin
            nibble = TP_HDR0;
        end else if (idx == 5'd1) begin
            nibble = TP_HDR1;
        end else if (idx < 5'd4) begin
            nibble = 4'h0;
        end else if (idx < 5'd8) begin
            if (!present[idx[1:0]])
                nibble = TP_TYPE_NONE;
            else if (six[idx[1:0]])
                nibble = TP_TYPE_6BTN;
            else
                nibble = TP_TYPE_3BTN;
        end else if (found) begin
            case (sub)
                5'd0:    nibble = btn[3:0];
                5'd1:    nibble = {btn[7], btn[4], btn[6], btn[5]};
                default: nibble = {btn[8], btn[9], btn[10], btn[11]};
            endcase
        end
    end

    assign last = (idx == 5'd7 + total);

endmodule

// File: rtl/gen_teamplayer.sv
// Team Player four-pad multitap on Genesis port B. Optional 6-button support
// is enabled by defining GEN_TEAMPLAYER_SIXBTN_EN.
module gen_teamplayer
    import gen_io_pkg::*;
#(
    parameter int unsigned WDOG_TICKS = 11600
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        TH_IN,
    input  logic        TR_IN,
    input  logic [3:0]  PAD_PRESENT,
    input  logic [3:0]  PAD_SIX,
    input  logic [47:0] PAD_BTN,
    output logic [6:0]  DO
);

    localparam logic [16:0] WDOG_LIM = 17'(WDOG_TICKS);

    tp_state_t   state_q, state_n;
    logic [4:0]  idx_q, idx_n, sel_idx, idx_inc;
    logic [3:0]  nib_q, nib_n, sel_nib;
    logic        sel_last, last_q, last_n;
    logic        tl_q, tl_n;
    logic [16:0] cnt_q, cnt_n;
    logic [3:0]  pres_q, pres_n, six_q, six_n, six_src;
    logic        th_q, th_d, tr_q, tr_d;
    logic        th_fall, tr_edge;

`ifdef GEN_TEAMPLAYER_SIXBTN_EN
    assign six_src = PAD_SIX & PAD_PRESENT;
`else
    logic unused_six;
    assign unused_six = ^PAD_SIX;
    assign six_src    = '0;
`endif

    assign th_fall = th_d & ~th_q;
    assign tr_edge = tr_q ^ tr_d;
    assign idx_inc = (idx_q == 5'd31) ? idx_q : idx_q + 5'd1;
    assign sel_idx = th_fall ? 5'd1 : idx_inc;

    tp_nibble_sel u_sel (
        .present (pres_q),
        .six     (six_q),
        .idx     (sel_idx),
        .pad_btn (PAD_BTN),
        .nibble  (sel_nib),
        .last    (sel_last)
    );

    // The last flag travels with the nibble on DO, so the TR edge after the
    // final nibble is the one that moves the packet into END.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        nib_n   = nib_q;
        last_n  = last_q;
        tl_n    = tl_q;
        cnt_n   = cnt_q;
        pres_n  = pres_q;
        six_n   = six_q;
        if (th_q) begin
            state_n = IDLE;
            idx_n   = '0;
            nib_n   = TP_HDR0;
            last_n  = 1'b0;
            tl_n    = 1'b1;
            cnt_n   = '0;
        end else if (th_fall) begin
            state_n = HDR;
            idx_n   = 5'd1;
            nib_n   = TP_HDR1;
            last_n  = 1'b0;
            cnt_n   = '0;
            pres_n  = PAD_PRESENT;
            six_n   = six_src;
        end else if (tr_edge) begin
            cnt_n = '0;
            tl_n  = tr_q;
            if (state_q == END || state_q == IDLE || last_q) begin
                state_n = END;
                idx_n   = idx_inc;
                nib_n   = TP_HDR1;
                last_n  = 1'b0;
            end else begin
                idx_n  = sel_idx;
                nib_n  = sel_nib;
                last_n = sel_last;
                if (sel_idx < 5'd4)
                    state_n = HDR;
                else if (sel_idx < 5'd8)
                    state_n = TYPE;
                else
                    state_n = DATA;
            end
        end else begin
            if (cnt_q != '1)
                cnt_n = cnt_q + 17'd1;
            if (cnt_q >= WDOG_LIM) begin
                state_n = END;
                nib_n   = TP_HDR1;
                last_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= IDLE;
        else if (CE)
            state_q <= state_n;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q  <= '0;
            nib_q  <= TP_HDR0;
            last_q <= 1'b0;
            tl_q   <= 1'b1;
            cnt_q  <= '0;
            pres_q <= '0;
            six_q  <= '0;
            th_q   <= 1'b1;
            th_d   <= 1'b1;
            tr_q   <= 1'b1;
            tr_d   <= 1'b1;
        end else if (CE) begin
            idx_q  <= idx_n;
            nib_q  <= nib_n;
            last_q <= last_n;
            tl_q   <= tl_n;
            cnt_q  <= cnt_n;
            pres_q <= pres_n;
            six_q  <= six_n;
            th_q   <= TH_IN;
            th_d   <= th_q;
            tr_q   <= TR_IN;
            tr_d   <= tr_q;
        end
    end

    assign DO = {th_q, tr_q, tl_q, nib_q};

endmodule
